// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer: state encoding, time
// scaling and preset-field helpers.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } cd_state_t;

  localparam int MAX_TIME   = 359999;
  localparam int CS_PER_MIN = 6000;
  localparam int CS_PER_SEC = 100;
  localparam int FIELD_MAX  = 59;

  function automatic logic [18:0] preset_to_cs(input logic [5:0] mins,
                                               input logic [5:0] secs);
    return 19'(int'(mins) * CS_PER_MIN + int'(secs) * CS_PER_SEC);
  endfunction

  // Minute and second fields wrap independently; no carry between them.
  function automatic logic [5:0] field_inc(input logic [5:0] f);
    return (f == 6'(FIELD_MAX)) ? 6'd0 : f + 6'd1;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus falling-edge detector for an active-low button;
// emits a single-cycle press pulse per press.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign press = prev_reg & ~sync2_reg;

endmodule

// File: rtl/countdown_timer.sv
// Centisecond countdown timer with minute/second preset, pause, abort and a
// flashing alarm on the LED bar.
module countdown_timer #(
  parameter int TICK_DIV    = 500000,
  parameter int BLINK_TICKS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic        key_min,
  input  logic        key_sec,
  output logic [18:0] time_remaining,
  output logic [1:0]  state,
  output logic        alarm,
  output logic [9:0]  led
);
  import countdown_pkg::*;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [3:0] key_raw;
  logic [3:0] press_vec;

  assign key_raw = {key_sec, key_min, key_pause, key_start};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_edge u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_raw[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  cd_state_t   state_reg;
  logic [5:0]  min_reg;
  logic [5:0]  sec_reg;
  logic [18:0] tr_reg;
  logic [PW-1:0] presc_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic        blink_on_reg;
  logic        alarm_reg;

  logic start_act, pause_act, min_act, sec_act, any_press;
  logic presc_adv, tick;
  logic [5:0]  min_inc, sec_inc;
  logic [18:0] reload_cs;

  // Only the highest-priority key of a simultaneous group is acted on.
  assign start_act = press_vec[0];
  assign pause_act = press_vec[1] & ~press_vec[0];
  assign min_act   = press_vec[2] & ~(|press_vec[1:0]);
  assign sec_act   = press_vec[3] & ~(|press_vec[2:0]);
  assign any_press = |press_vec;

  assign min_inc   = field_inc(min_reg);
  assign sec_inc   = field_inc(sec_reg);
  assign reload_cs = preset_to_cs(min_reg, sec_reg);

  // The pause edge holds the prescaler and the resume edge advances it, so the
  // count of advancing cycles equals the cycles spent showing RUN.
  assign presc_adv = ((state_reg == ST_RUN) && !start_act && !pause_act) ||
                     ((state_reg == ST_PAUSE) && pause_act) ||
                     ((state_reg == ST_ALARM) && !any_press);
  assign tick      = presc_adv && (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      min_reg       <= '0;
      sec_reg       <= '0;
      tr_reg        <= '0;
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b0;
      alarm_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_act) begin
            if ((min_reg != 6'd0) || (sec_reg != 6'd0)) begin
              state_reg <= ST_RUN;
              presc_reg <= '0;
            end
          end else if (min_act) begin
            min_reg <= min_inc;
            tr_reg  <= preset_to_cs(min_inc, sec_reg);
          end else if (sec_act) begin
            sec_reg <= sec_inc;
            tr_reg  <= preset_to_cs(min_reg, sec_inc);
          end
        end
        ST_RUN: begin
          if (start_act) begin
            state_reg <= ST_IDLE;
            tr_reg    <= reload_cs;
          end else if (pause_act) begin
            state_reg <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (start_act) begin
            state_reg <= ST_IDLE;
            tr_reg    <= reload_cs;
          end else if (pause_act) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          if (any_press) begin
            state_reg <= ST_IDLE;
            alarm_reg <= 1'b0;
            tr_reg    <= reload_cs;
          end else if (tick) begin
            if (blink_cnt_reg == BW'(BLINK_TICKS - 1)) begin
              blink_cnt_reg <= '0;
              blink_on_reg  <= ~blink_on_reg;
            end else begin
              blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
          end
        end
      endcase

      if (presc_adv)
        presc_reg <= tick ? '0 : presc_reg + PW'(1);

      if (tick && (state_reg != ST_ALARM)) begin
        if (tr_reg == 19'd1) begin
          tr_reg        <= '0;
          state_reg     <= ST_ALARM;
          alarm_reg     <= 1'b1;
          blink_cnt_reg <= '0;
          blink_on_reg  <= 1'b1;
        end else begin
          tr_reg <= tr_reg - 19'd1;
        end
      end
    end
  end

  logic [18:0] tens_cs;
  logic [3:0]  dot_pos;

  assign tens_cs = tr_reg / 19'd10;
  assign dot_pos = 4'(tens_cs % 19'd10);

  always_comb begin
    led = '0;
    case (state_reg)
      ST_RUN, ST_PAUSE: led = 10'd1 << dot_pos;
      ST_ALARM:         led = blink_on_reg ? '1 : '0;
      default:          led = '0;
    endcase
  end

  assign time_remaining = tr_reg;
  assign state          = state_reg;
  assign alarm          = alarm_reg;

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown companion to the stopwatch on the same board: the user presets a time in minutes and seconds with the keys, starts it, and the block decrements in centiseconds to zero, then raises an alarm. `time_remaining` uses the stopwatch's centisecond encoding (0..359999 = 59:59.99), so it drives the existing six-digit seven-segment display path unchanged. The LED bar shows run activity and flashes at alarm.

## Interface
Parameters:
- `TICK_DIV`, default 500000: `clk` cycles per 10 ms tick (50 MHz board clock).
- `BLINK_TICKS`, default 25: ticks per alarm LED toggle (2 Hz flash).

Ports:
- `clk`  in  1  board clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_start`  in  1  raw push button, active-low, debounced externally: start/abort/acknowledge.
- `key_pause`  in  1  raw push button, active-low: pause/resume.
- `key_min`  in  1  raw push button, active-low: add one minute to the preset.
- `key_sec`  in  1  raw push button, active-low: add one second to the preset.
- `time_remaining`  out  19  centiseconds left, 0..359999.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- `alarm`  out  1  high while in ALARM.
- `led`  out  10  status bar.

## Operation
- Each key passes a 2-flop synchronizer and a falling-edge detector. This gives a one-cycle `press` pulse per key press.
- Key priority when several presses land in one cycle: start > pause > min > sec. Only the highest-priority key is acted on; the others are dropped.
- IDLE:
  - `time_remaining` = `preset`.
  - min press adds 1 to the minutes field; sec press adds 1 to the seconds field.
  - Each field wraps 59→0 and never carries into the other field; centiseconds stay 0.
  - start press with `preset` ≠ 0 → RUN and the prescaler clears to 0. With `preset` = 0 the press is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. A tick occurs on wrap, and each tick decrements `time_remaining` by 1.
  - A decrement from 1 to 0 → ALARM in the same cycle, with the blink counter cleared.
  - pause press → PAUSE. No decrement happens in that cycle, even if a tick coincides.
  - start press → IDLE and `time_remaining` reloads `preset` (abort).
  - min/sec presses are ignored.
- PAUSE:
  - Prescaler and `time_remaining` hold.
  - pause press → RUN; the prescaler resumes from its held value.
  - start press → IDLE with reload.
- ALARM:
  - `time_remaining` = 0 and `alarm` = 1.
  - Any key press → IDLE with reload. The preset is kept, so start re-arms the same time.
- `led`:
  - IDLE: 0.
  - RUN/PAUSE: `1 << ((time_remaining/10) % 10)`, a dot that walks downward as time drains.
  - ALARM: all-ones or all-zeros, toggling every BLINK_TICKS ticks, starting all-ones.
- Arithmetic:
  - `preset` is kept internally as min[5:0] and sec[5:0] fields.
  - `time_remaining` reload = min·6000 + sec·100.
  - The decrement never underflows, because RUN is left at 0.

## Timing
- Reset values: `state` = IDLE, `preset` = 0, `time_remaining` = 0, `alarm` = 0, `led` = 0, prescaler = 0, blink counter = 0, synchronizer flops = 1 (keys idle high).
- Reset mid-operation returns to these values immediately and asynchronously.
- Key latency: a key sampled low at edge n (after being high at n-1) produces `press` in the cycle after edge n+1. The action is visible on outputs after edge n+2.
- A held key produces exactly one press; release produces nothing.
- First decrement occurs TICK_DIV cycles after the edge that enters RUN.
- Count resolution is exactly TICK_DIV cycles per centisecond in RUN. PAUSE adds no cycles to the remaining count.
- All outputs are registered or decoded from registers only; no key-to-output combinational path exists.

## Structure
- Package `countdown_pkg` holds:
  - the state encoding, type `cd_state_t`;
  - `MAX_TIME` = 359999, `CS_PER_MIN` = 6000, `CS_PER_SEC` = 100;
  - `FIELD_MAX` = 59.
- Sub-module `key_edge` (synchronizer plus falling-edge detector, output `press`) is instantiated four times.
- Prescaler, FSM, preset fields and LED decode live in the top module.

## Test plan
(Benches use TICK_DIV = 4, BLINK_TICKS = 2.)
- Reset, then press min 2× and sec 3× → `time_remaining` = 12300, `state` = IDLE, `led` = 0.
- Press sec 60× from 0 → seconds field reads 0 and minutes are unchanged. Press min 60× → minutes field wraps to 0.
- Preset 0:01, start → exactly 100 ticks (400 cycles) later `state` = ALARM and `alarm` = 1. `led` toggles 0x3FF/0x000 every 8 cycles. Any key → IDLE with `time_remaining` = 100.
- Preset 0:01, start, pause after 10 ticks, hold 50 cycles, resume → ALARM is reached 450 cycles after start. Pause+min pressed in the same cycle → only pause acts.
- Start with `preset` = 0 → stays IDLE. Start pressed in RUN at `time_remaining` = 57 → IDLE with reload to the preset value.
- Assert `rst_n` low during RUN, then high → all outputs return to reset values.
